// File: rtl/sync_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// sync_accumulator_pkg
// Shared types for the frame accumulator that sits behind the adder tree.
//   acc_state_e : control state of the accumulator (waiting for the first
//                 sync, or free-running accumulation).
// -----------------------------------------------------------------------------
`ifndef SYNC_ACCUMULATOR_PKG_SV
`define SYNC_ACCUMULATOR_PKG_SV

package sync_accumulator_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

endpackage

`endif

// File: rtl/sync_accumulator_adder.sv
// -----------------------------------------------------------------------------
// sync_accumulator_adder
// Width-growth adder: sum = a + ext(b). Here ext() is a sign or zero extension
// of b to A_WIDTH. The result is A_WIDTH bits wide. The caller sizes A_WIDTH
// so the sum cannot overflow.
//   clk, rst : used only when REGISTER_OUTPUT == "TRUE" (sync active-high rst)
//   a        : A_WIDTH running operand
//   b        : B_WIDTH operand, extended per IS_SIGNED (A_WIDTH > B_WIDTH)
//   sum      : A_WIDTH result, combinational or registered
// -----------------------------------------------------------------------------
`ifndef SYNC_ACCUMULATOR_ADDER_SV
`define SYNC_ACCUMULATOR_ADDER_SV

module sync_accumulator_adder #(
    parameter int    A_WIDTH         = 9,
    parameter int    B_WIDTH         = 7,
    parameter string IS_SIGNED       = "TRUE",
    parameter string REGISTER_OUTPUT = "FALSE"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [A_WIDTH-1:0] sum
);

    logic [A_WIDTH-1:0] b_ext_s;
    logic [A_WIDTH-1:0] sum_s;

    // Extend b to the accumulator width, replicating the sign bit when signed.
    always_comb begin
        b_ext_s = {A_WIDTH{1'b0}};
        if (IS_SIGNED == "TRUE") begin
            b_ext_s = {{(A_WIDTH-B_WIDTH){b[B_WIDTH-1]}}, b};
        end else begin
            b_ext_s = {{(A_WIDTH-B_WIDTH){1'b0}}, b};
        end
    end

    assign sum_s = a + b_ext_s;

    generate
        if (REGISTER_OUTPUT == "TRUE") begin : g_reg
            logic [A_WIDTH-1:0] sum_r;

            // Optional output pipeline stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_r <= {A_WIDTH{1'b0}};
                end else begin
                    sum_r <= sum_s;
                end
            end

            assign sum = sum_r;
        end else begin : g_comb
            // Clock and reset are intentionally unused in the combinational form.
            logic unused_s;
            assign unused_s = clk ^ rst;
            assign sum      = sum_s;
        end
    endgenerate

endmodule

`endif

// File: rtl/sync_accumulator.sv
// -----------------------------------------------------------------------------
// sync_accumulator
// Sums 2^ACC_LEN_BITS consecutive adder-tree samples into one frame result.
// Frames are aligned to the tree's sync pulse.
//   clk        : clock
//   rst        : synchronous active-high reset; it has priority over all inputs
//   sync       : one-cycle pulse; din on the same cycle is sample 0 of a frame
//   din        : IN_WIDTH sample, valid every cycle
//   dout       : OUT_WIDTH registered frame sum, held between strobes
//   dout_valid : one-cycle strobe when dout updates
//   sync_out   : marks the first result after each sync (only with dout_valid)
// -----------------------------------------------------------------------------
`ifndef SYNC_ACCUMULATOR_SV
`define SYNC_ACCUMULATOR_SV

module sync_accumulator
    import sync_accumulator_pkg::*;
#(
    parameter int    IN_WIDTH     = 7,
    parameter int    ACC_LEN_BITS = 2,
    parameter string IS_SIGNED    = "TRUE",
    localparam int   OUT_WIDTH    = IN_WIDTH + ACC_LEN_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync,
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 sync_out
);

    localparam logic [ACC_LEN_BITS-1:0] CNT_LAST = {ACC_LEN_BITS{1'b1}};
    localparam logic [ACC_LEN_BITS-1:0] CNT_ONE  = ACC_LEN_BITS'(1);

    acc_state_e             state_r;
    logic [ACC_LEN_BITS-1:0] cnt_r;
    logic [OUT_WIDTH-1:0]    acc_r;
    logic                    pending_r;

    logic [ACC_LEN_BITS-1:0] cnt_eff_s;
    logic [OUT_WIDTH-1:0]    acc_sel_s;
    logic [OUT_WIDTH-1:0]    sum_s;

    // A sync forces this cycle to be sample 0, so the previous partial sum is
    // dropped and the count restarts whatever cnt_r currently holds.
    always_comb begin
        cnt_eff_s = cnt_r;
        acc_sel_s = acc_r;
        if (sync) begin
            cnt_eff_s = {ACC_LEN_BITS{1'b0}};
        end else begin
            cnt_eff_s = cnt_r;
        end
        if (cnt_eff_s == {ACC_LEN_BITS{1'b0}}) begin
            acc_sel_s = {OUT_WIDTH{1'b0}};
        end else begin
            acc_sel_s = acc_r;
        end
    end

    sync_accumulator_adder #(
        .A_WIDTH         (OUT_WIDTH),
        .B_WIDTH         (IN_WIDTH),
        .IS_SIGNED       (IS_SIGNED),
        .REGISTER_OUTPUT ("FALSE")
    ) u_adder (
        .clk (clk),
        .rst (rst),
        .a   (acc_sel_s),
        .b   (din),
        .sum (sum_s)
    );

    // Control FSM, running sum, frame counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {ACC_LEN_BITS{1'b0}};
            acc_r      <= {OUT_WIDTH{1'b0}};
            pending_r  <= 1'b0;
            dout       <= {OUT_WIDTH{1'b0}};
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dout_valid <= 1'b0;
                    sync_out   <= 1'b0;
                    if (sync) begin
                        // The sync cycle already carries sample 0.
                        state_r   <= ST_ACCUM;
                        acc_r     <= sum_s;
                        cnt_r     <= cnt_eff_s + CNT_ONE;
                        pending_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    state_r <= ST_ACCUM;
                    acc_r   <= sum_s;
                    cnt_r   <= cnt_eff_s + CNT_ONE;
                    if (sync) begin
                        // A restart wins, even on the last sample of a frame.
                        pending_r  <= 1'b1;
                        dout_valid <= 1'b0;
                        sync_out   <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        dout       <= sum_s;
                        dout_valid <= 1'b1;
                        sync_out   <= pending_r;
                        pending_r  <= 1'b0;
                    end else begin
                        dout_valid <= 1'b0;
                        sync_out   <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= {ACC_LEN_BITS{1'b0}};
                    acc_r      <= {OUT_WIDTH{1'b0}};
                    pending_r  <= 1'b0;
                    dout_valid <= 1'b0;
                    sync_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`endif

// File: tb/tb_sync_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sync_accumulator
// Directed bench for sync_accumulator (IN_WIDTH=7, ACC_LEN_BITS=2, signed).
// Inputs change #1 after a rising edge; outputs are checked #1 after the edge
// that consumed them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_accumulator;

    logic       clk;
    logic       rst;
    logic       sync;
    logic [6:0] din;
    logic [8:0] dout;
    logic       dout_valid;
    logic       sync_out;

    int         n_checks;
    int         n_errors;
    logic [8:0] dout_hold;

    sync_accumulator #(
        .IN_WIDTH     (7),
        .ACC_LEN_BITS (2),
        .IS_SIGNED    ("TRUE")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_out   (sync_out)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and wait until the outputs reflect it.
    task automatic step(input logic s, input logic [6:0] d);
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    // Outputs expected when no result is produced this cycle.
    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_sync"},  {31'd0, sync_out},   32'd0);
        check({tag, "_hold"},  {23'd0, dout},       {23'd0, dout_hold});
    endtask

    // Four samples of one frame; the first may carry a sync pulse.
    task automatic frame(input string tag, input logic first_sync,
                         input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3,
                         input logic [8:0] exp_sum, input logic exp_sync);
        logic [6:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            step((i == 0) ? first_sync : 1'b0, d[i]);
            if (i < 3) begin
                check_quiet(tag);
            end else begin
                check({tag, "_valid"}, {31'd0, dout_valid}, 32'd1);
                check({tag, "_dout"},  {23'd0, dout},       {23'd0, exp_sum});
                check({tag, "_sync"},  {31'd0, sync_out},   {31'd0, exp_sync});
                dout_hold = exp_sum;
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        dout_hold = 9'd0;
        rst       = 1'b1;
        sync      = 1'b0;
        din       = 7'd0;

        // Reset held for 3 cycles with random stimulus.
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 7'($urandom));
            check("reset_dout",  {23'd0, dout},       32'd0);
            check("reset_valid", {31'd0, dout_valid}, 32'd0);
            check("reset_sync",  {31'd0, sync_out},   32'd0);
        end
        rst = 1'b0;

        // Samples without any sync must never produce a result.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 7'(i + 3));
            check_quiet("nosync");
        end

        // Basic frame, then back-to-back frames and signed extremes.
        frame("basic",  1'b1, 7'd1,    7'd2,    7'd3,    7'd4,    9'h00A, 1'b1);
        frame("b2b",    1'b0, 7'd5,    7'd5,    7'd5,    7'd5,    9'h014, 1'b0);
        frame("neg",    1'b0, 7'h40,   7'h40,   7'h40,   7'h40,   9'h100, 1'b0);
        frame("pos",    1'b0, 7'h3F,   7'h3F,   7'h3F,   7'h3F,   9'h0FC, 1'b0);
        frame("alt",    1'b0, 7'h3F,   7'h40,   7'h3F,   7'h40,   9'h1FE, 1'b0);

        // Sync mid-frame: 7, 7 are discarded and only the restarted frame is emitted.
        step(1'b1, 7'd7);
        check_quiet("mid_a");
        step(1'b0, 7'd7);
        check_quiet("mid_b");
        frame("mid", 1'b1, 7'd1, 7'd1, 7'd1, 7'd1, 9'h004, 1'b1);

        // Sync on the last-sample slot: the completing frame is dropped.
        step(1'b0, 7'd9);
        check_quiet("last_a");
        step(1'b0, 7'd9);
        check_quiet("last_b");
        step(1'b0, 7'd9);
        check_quiet("last_c");
        frame("last", 1'b1, 7'd3, 7'd3, 7'd3, 7'd3, 9'h00C, 1'b1);

        // Reset mid-frame clears the outputs and waits for a fresh sync.
        step(1'b1, 7'd5);
        check_quiet("rmid_a");
        step(1'b0, 7'd5);
        check_quiet("rmid_b");
        rst = 1'b1;
        step(1'b0, 7'd5);
        rst = 1'b0;
        dout_hold = 9'd0;
        check("rmid_dout",  {23'd0, dout},       32'd0);
        check("rmid_valid", {31'd0, dout_valid}, 32'd0);
        check("rmid_sync",  {31'd0, sync_out},   32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 7'd2);
            check_quiet("rmid_idle");
        end
        frame("after_rst", 1'b1, 7'd2, 7'd2, 7'd2, 7'd2, 9'h008, 1'b1);

        // The strobe lasts exactly one cycle and dout holds afterwards.
        step(1'b0, 7'd0);
        check_quiet("tail");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_accumulator.md
# sync_accumulator

Integrates the stream of reduced samples that the adder tree produces. It sums `2^ACC_LEN_BITS` consecutive tree outputs into one wide result per frame. Frame boundaries are set by the tree's `sync_out` pulse, which arrives aligned with the tree's `dout`. The block sits directly downstream of the adder tree and feeds the readout/packetiser stage with one registered result plus a valid strobe per frame.

## Interface
Parameters:
- `IN_WIDTH`, default 7: width of one input sample. This matches the tree output width `INPUT_WIDTH + PARALLEL_SAMPLE_BITS`.
- `ACC_LEN_BITS`, default 2: there are `2^ACC_LEN_BITS` samples per frame. Must be ≥ 1.
- `IS_SIGNED`, default "TRUE": when "TRUE", `din` is two's complement and is sign-extended. Otherwise it is zero-extended.
- `OUT_WIDTH`, localparam: `IN_WIDTH + ACC_LEN_BITS`.

Ports:
- `clk`, input, 1: the single clock for the block.
- `rst`, input, 1: synchronous, active-high reset.
- `sync`, input, 1: single-cycle pulse. The `din` on the same cycle is sample 0 of a new frame.
- `din`, input, `IN_WIDTH`: tree output sample, valid every cycle.
- `dout`, output, `OUT_WIDTH`: registered frame sum. Held until the next result.
- `dout_valid`, output, 1: one-cycle strobe when `dout` updates.
- `sync_out`, output, 1: one-cycle pulse coincident with the first `dout_valid` after each `sync`.

## Operation
- State machine with two states:
  - `IDLE`: after reset. `din` is ignored. `sync` moves the block to `ACCUM` with count = 0.
  - `ACCUM`: free-running. Stays in `ACCUM` until `rst` is asserted.
- Sample counter `cnt`, `ACC_LEN_BITS` wide:
  - `cnt` = 0 on a `sync` cycle.
  - Otherwise `cnt` increments each cycle in `ACCUM` and wraps from `2^ACC_LEN_BITS − 1` to 0 with no gap, so the next frame starts on the following cycle.
- Running sum, computed each `ACCUM` cycle (including the `sync` cycle):
  - `sum = (cnt==0 ? 0 : acc) + ext(din)`, where `ext` is a sign- or zero-extension to `OUT_WIDTH`.
  - `acc <= sum`.
- Frame completion: when `cnt == 2^ACC_LEN_BITS − 1`, the block sets `dout <= sum` and `dout_valid <= 1` on the next edge.
- Overflow is impossible by construction: `OUT_WIDTH` holds the full signed or unsigned range, so no saturation logic is needed.
- `sync` while in `ACCUM`:
  - The partial frame is discarded and no `dout_valid` is produced for it.
  - The current `din` becomes sample 0.
  - A pending-sync flag is set. It is cleared when the next `dout_valid` fires, and `sync_out` is driven on that same cycle.
- `sync` on the last-sample cycle of a frame: the restart wins. The frame completing on that cycle is not emitted.
- `rst` has priority over every other input. Reset values:
  - state = `IDLE`
  - `cnt` = 0, `acc` = 0
  - `dout` = 0, `dout_valid` = 0, `sync_out` = 0
  - pending flag = 0
- `rst` asserted mid-frame aborts the frame. The block then waits for a fresh `sync`.

## Timing
- Latency: one clock from the last sample of a frame to `dout_valid`/`dout`.
- Throughput: one input sample per clock. One result every `2^ACC_LEN_BITS` clocks in steady state.
- `dout` holds its value between strobes. Consumers must sample it on `dout_valid`.
- `sync_out` never asserts without `dout_valid` on the same cycle.
- First result after `sync` at cycle t: `dout_valid` at cycle `t + 2^ACC_LEN_BITS`.

## Structure
- Single Verilog file with an `ifndef` guard, consistent with the general library.
- No shared package is required. The state encodings (`IDLE`, `ACCUM`) and `OUT_WIDTH` are local parameters.
- The width-growth add is a natural sub-module: instantiate the existing `adder` with `A_WIDTH = OUT_WIDTH`, `B_WIDTH = IN_WIDTH`, signedness from `IS_SIGNED`, and `REGISTER_OUTPUT = "FALSE"`. Registering is done in this block.

## Test plan
All scenarios use `IN_WIDTH = 7`, `ACC_LEN_BITS = 2`, `IS_SIGNED = "TRUE"`.
- Reset: hold `rst` for 3 cycles with random `din`/`sync` → `dout` = 0, `dout_valid` = 0, `sync_out` = 0 throughout. `din` with no `sync` afterwards → no `dout_valid` ever.
- Basic frame: `sync` with `din` = 1, then 2, 3, 4 → on the next cycle `dout` = 10, `dout_valid` = 1, `sync_out` = 1, both for exactly one cycle.
- Back-to-back frames: continue with `din` = 5, 5, 5, 5 and no `sync` → `dout` = 20 with `dout_valid` 4 cycles after the previous strobe, `sync_out` = 0.
- Signed extremes:
  - `din` = −64 ×4 → `dout` = −256 (9'h100).
  - `din` = 63 ×4 → `dout` = 252.
  - Alternating 63/−64 → −2.
- Sync mid-frame: `sync` with 7, 7, then `sync` again with 1, 1, 1, 1 → the only result is `dout` = 4 with `sync_out` = 1. No strobe for the aborted 14.
- Reset mid-frame: `rst` after 2 samples → outputs zero, no result. A later `sync` with 2, 2, 2, 2 → `dout` = 8 with `sync_out` = 1.
